// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for mem_port_arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GRANT_I, GRANT_D)
//   arb_req_t   : requester identity, used for the last-grant record
//   WORD_MASK   : clears the byte offset to form a word-aligned address
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_t;

    typedef enum logic {
        REQ_INST,
        REQ_DATA
    } arb_req_t;

    // Wide enough for any supported ADDR_W; callers slice to width.
    localparam logic [63:0] WORD_MASK = ~64'h3;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one physical memory port between the instruction-fetch
// and data requesters. One transaction at a time; the granted request is captured
// into registers and driven downstream until pmem_resp, then an IDLE cycle follows.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   i_read, i_addr            fetch request; i_rdata/i_resp return path
//   d_read, d_write, d_addr,  data request (write wins if both read and write set);
//   d_wdata, d_byte_enable    d_rdata/d_resp return path
//   pmem_read/write/addr/     downstream request, registered, held until pmem_resp
//   wdata/byte_enable
//   pmem_rdata, pmem_resp     downstream response
//
// Configuration
//   ARB_ROUND_ROBIN_EN : when defined, ties go to the requester not granted last.
//                        When undefined, ties go to data (fixed priority).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,

    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_enable,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,

    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_addr,
    output logic [DATA_W-1:0]   pmem_wdata,
    output logic [DATA_W/8-1:0] pmem_byte_enable,
    input  logic [DATA_W-1:0]   pmem_rdata,
    input  logic                pmem_resp
);

    localparam int unsigned BeW = DATA_W / 8;

    arb_state_t          state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BeW-1:0]      be_q, be_d;

    logic                i_pend;
    logic                d_pend;
    logic                prefer_data;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    arb_req_t            last_q, last_d;
    // Data wins a tie only if fetch was granted last.
    assign prefer_data = (last_q == REQ_INST);
`else
    assign prefer_data = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (d_pend && (!i_pend || prefer_data)) begin
                    state_d = GRANT_D;
                    // A simultaneous read+write is treated as a write.
                    write_d = d_write;
                    addr_d  = d_addr & WORD_MASK[ADDR_W-1:0];
                    wdata_d = d_wdata;
                    be_d    = d_write ? d_byte_enable : {BeW{1'b1}};
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = REQ_DATA;
`endif
                end else if (i_pend) begin
                    state_d = GRANT_I;
                    write_d = 1'b0;
                    addr_d  = i_addr & WORD_MASK[ADDR_W-1:0];
                    wdata_d = '0;
                    be_d    = {BeW{1'b1}};
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = REQ_INST;
`endif
                end
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= REQ_INST;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Request strobes decode straight from reset-cleared state, so an async reset
    // drops them at once with no clock edge.
    assign pmem_read        = (state_q != IDLE) && !write_q;
    assign pmem_write       = (state_q != IDLE) && write_q;
    assign pmem_addr        = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;

    assign i_resp  = pmem_resp && (state_q == GRANT_I);
    assign d_resp  = pmem_resp && (state_q == GRANT_D);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for contention, async reset and spurious responses.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_read           (i_read),
        .i_addr           (i_addr),
        .i_rdata          (i_rdata),
        .i_resp           (i_resp),
        .d_read           (d_read),
        .d_write          (d_write),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_byte_enable    (d_byte_enable),
        .d_rdata          (d_rdata),
        .d_resp           (d_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_addr        (pmem_addr),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        i_read;
        logic [31:0] i_addr;
        logic        d_read;
        logic        d_write;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        int          lat;
        logic [31:0] rdata;
        logic        exp_data;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_write;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Entered just after a rising edge with the arbiter in IDLE.
    task automatic run_vec(input vec_t v);
        i_read        = v.i_read;
        i_addr        = v.i_addr;
        d_read        = v.d_read;
        d_write       = v.d_write;
        d_addr        = v.d_addr;
        d_wdata       = v.d_wdata;
        d_byte_enable = v.d_be;
        @(posedge clk); #1;
        chk({v.name, " pmem_read"}, pmem_read, !v.exp_write);
        chk({v.name, " pmem_write"}, pmem_write, v.exp_write);
        chk({v.name, " pmem_addr"}, pmem_addr, v.exp_addr);
        chk({v.name, " pmem_be"}, pmem_byte_enable, v.exp_be);
        if (v.exp_write) chk({v.name, " pmem_wdata"}, pmem_wdata, v.d_wdata);
        // Requester inputs wander mid-transaction; captured values must hold.
        i_addr        = 32'h0000_BAD0;
        d_addr        = 32'h0000_BAD4;
        d_wdata       = 32'h0;
        d_byte_enable = 4'h0;
        for (int k = 1; k < v.lat; k++) begin
            @(posedge clk); #1;
            chk({v.name, " held req"}, {pmem_read, pmem_write}, {!v.exp_write, v.exp_write});
            chk({v.name, " no early resp"}, {i_resp, d_resp}, 2'b00);
        end
        pmem_rdata = v.rdata;
        pmem_resp  = 1'b1;
        #1;
        chk({v.name, " i_resp"}, i_resp, !v.exp_data);
        chk({v.name, " d_resp"}, d_resp, v.exp_data);
        chk({v.name, " rdata"}, v.exp_data ? d_rdata : i_rdata, v.rdata);
        chk({v.name, " addr stable"}, pmem_addr, v.exp_addr);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        #1;
        chk({v.name, " idle after"}, {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
    endtask

    initial begin
        vecs[0] = '{"fetch 0x60", 1, 32'h60, 0, 0, 32'h0, 32'h0, 4'h0, 3, 32'h00A0_0093,
                    0, 32'h60, 4'hF, 0};
        vecs[1] = '{"store 0x1006", 0, 32'h0, 0, 1, 32'h1006, 32'hDEAD_0000, 4'b1100, 2, 32'h0,
                    1, 32'h1004, 4'b1100, 1};
        vecs[2] = '{"load 0x2003", 0, 32'h0, 1, 0, 32'h2003, 32'h0, 4'h3, 1, 32'h1234_5678,
                    1, 32'h2000, 4'hF, 0};
        vecs[3] = '{"rd+wr 0x300", 0, 32'h0, 1, 1, 32'h300, 32'hCAFE_F00D, 4'b0001, 1, 32'h0,
                    1, 32'h300, 4'b0001, 1};
        vecs[4] = '{"fetch top", 1, 32'h7FFF_FFFE, 0, 0, 32'h0, 32'h0, 4'h0, 2, 32'hFFFF_FFFF,
                    0, 32'h7FFF_FFFC, 4'hF, 0};

        rst = 1'b1;
        i_read = 0; i_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
        d_byte_enable = 0; pmem_rdata = 0; pmem_resp = 0;
        #1 rst = 1'b0;
        #3;
        chk("reset req", {pmem_read, pmem_write}, 2'b00);
        chk("reset addr", pmem_addr, 32'h0);
        chk("reset wdata", pmem_wdata, 32'h0);
        chk("reset be", pmem_byte_enable, 4'h0);
        chk("reset resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 5; n++) run_vec(vecs[n]);

        // Tie after a fetch grant: data first in both builds, then IDLE, then fetch.
        i_read = 1; i_addr = 32'h400; d_read = 1; d_addr = 32'h804;
        @(posedge clk); #1;
        chk("tie1 first addr", pmem_addr, 32'h804);
        pmem_rdata = 32'h11; pmem_resp = 1; #1;
        chk("tie1 first resp", {i_resp, d_resp}, 2'b01);
        @(posedge clk); #1;
        pmem_resp = 0; d_read = 0; #1;
        chk("tie1 idle gap", {pmem_read, pmem_write}, 2'b00);
        @(posedge clk); #1;
        chk("tie1 second req", pmem_read, 1'b1);
        chk("tie1 second addr", pmem_addr, 32'h400);
        pmem_resp = 1; #1;
        chk("tie1 second resp", {i_resp, d_resp}, 2'b10);
        @(posedge clk); #1;
        pmem_resp = 0; i_read = 0;

        // Data-only grant, then a tie: round-robin picks fetch, fixed picks data.
        d_read = 1; d_addr = 32'h900;
        @(posedge clk); #1;
        pmem_resp = 1;
        @(posedge clk); #1;
        pmem_resp = 0; d_read = 0;
        i_read = 1; i_addr = 32'h440; d_read = 1; d_addr = 32'h880;
        @(posedge clk); #1;
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie2 winner addr", pmem_addr, 32'h440);
`else
        chk("tie2 winner addr", pmem_addr, 32'h880);
`endif
        pmem_resp = 1;
        @(posedge clk); #1;
        pmem_resp = 0; i_read = 0; d_read = 0;
        @(posedge clk); #1;

        // Async reset mid-store: strobes fall between clock edges, late resp is ignored.
        d_write = 1; d_addr = 32'hA0; d_wdata = 32'h55; d_byte_enable = 4'hF;
        @(posedge clk); #1;
        chk("abort pre write", pmem_write, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort async drop", {pmem_read, pmem_write}, 2'b00);
        chk("abort addr clear", pmem_addr, 32'h0);
        d_write = 0;
        #3 rst = 1'b1;
        pmem_resp = 1; #1;
        chk("abort late resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk); #1;
        chk("spurious stays idle", {pmem_read, pmem_write}, 2'b00);
        chk("spurious no resp", {i_resp, d_resp}, 2'b00);
        pmem_resp = 0;
        @(posedge clk); #1;
        chk("final idle", {pmem_read, pmem_write}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
